// File: rtl/uart_ctrl_pkg.sv
// rtl/uart_ctrl_pkg.sv - shared state encodings and sizing helpers for uart_ctrl
package uart_ctrl_pkg;

  typedef enum logic [1:0] {
    T_IDLE,
    T_LOAD,
    T_WAIT_BUSY,
    T_WAIT_EMPTY
  } tx_state_e;

  typedef enum logic [1:0] {
    R_IDLE,
    R_CAPT,
    R_HOLD
  } rx_state_e;

  function automatic int tmo_cnt_w(input int busy_timeout);
    return $clog2(busy_timeout + 1);
  endfunction

endpackage

// File: rtl/uart_ctrl_rr_arbiter.sv
// rtl/uart_ctrl_rr_arbiter.sv - combinational round-robin select with frame-lock override
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    ptr_i,
  input  logic               lock_i,
  input  logic [ID_W-1:0]    lock_id_i,
  output logic               gnt_valid_o,
  output logic [ID_W-1:0]    gnt_id_o
);

  function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return s[ID_W-1:0];
  endfunction

  // Scan from the far end back toward the pointer so the closest request wins.
  always_comb begin
    gnt_valid_o = 1'b0;
    gnt_id_o    = '0;
    if (lock_i) begin
      gnt_valid_o = req_i[lock_id_i];
      gnt_id_o    = lock_id_i;
    end else begin
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
        if (req_i[wrap_idx(ptr_i, i)]) begin
          gnt_valid_o = 1'b1;
          gnt_id_o    = wrap_idx(ptr_i, i);
        end
      end
    end
  end

endmodule

// File: rtl/uart_ctrl.sv
// rtl/uart_ctrl.sv - arbitrates byte requesters onto the uart TX path and unloads uart RX bytes
module uart_ctrl
  import uart_ctrl_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int DATA_W       = 8,
  parameter int BUSY_TIMEOUT = 16,
  localparam int ID_W        = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [ID_W-1:0]           grant_id,
  output logic                      ld_tx_data,
  output logic [DATA_W-1:0]         tx_data,
  output logic                      tx_enable,
  input  logic                      tx_empty,
  output logic                      rx_enable,
  output logic                      uld_rx_data,
  input  logic [DATA_W-1:0]         rx_data,
  input  logic                      rx_empty,
  output logic [DATA_W-1:0]         rx_byte,
  output logic                      rx_valid,
  input  logic                      rx_ready,
  output logic                      busy,
  output logic                      timeout_err
);

  localparam int CNT_W = tmo_cnt_w(BUSY_TIMEOUT);

  tx_state_e             tx_state_q, tx_state_d;
  logic [ID_W-1:0]       ptr_q, ptr_d;
  logic                  lock_q, lock_d;
  logic [ID_W-1:0]       gid_q, gid_d;
  logic [DATA_W-1:0]     tx_data_q, tx_data_d;
  logic [NUM_REQ-1:0]    req_ready_q, req_ready_d;
  logic                  ld_q, ld_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  tmo_q, tmo_d;
  logic                  en_q;

  rx_state_e             rx_state_q, rx_state_d;
  logic                  uld_q, uld_d;
  logic [DATA_W-1:0]     rx_byte_q, rx_byte_d;
  logic                  rx_valid_q, rx_valid_d;

  logic                  gnt_valid;
  logic [ID_W-1:0]       gnt_id;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req_i       (req_valid),
    .ptr_i       (ptr_q),
    .lock_i      (lock_q),
    .lock_id_i   (gid_q),
    .gnt_valid_o (gnt_valid),
    .gnt_id_o    (gnt_id)
  );

  always_comb begin
    tx_state_d  = tx_state_q;
    ptr_d       = ptr_q;
    lock_d      = lock_q;
    gid_d       = gid_q;
    tx_data_d   = tx_data_q;
    req_ready_d = '0;
    ld_d        = 1'b0;
    cnt_d       = cnt_q;
    tmo_d       = tmo_q;
    case (tx_state_q)
      T_IDLE: begin
        if (enable && tx_empty && gnt_valid) begin
          tx_data_d           = req_data[int'(gnt_id)*DATA_W +: DATA_W];
          req_ready_d[gnt_id] = 1'b1;
          gid_d               = gnt_id;
          lock_d              = !req_last[gnt_id];
          if (req_last[gnt_id]) ptr_d = (int'(gnt_id) == NUM_REQ - 1) ? '0 : gnt_id + 1'b1;
          tx_state_d          = T_LOAD;
        end
      end
      T_LOAD: begin
        ld_d       = 1'b1;
        cnt_d      = '0;
        tx_state_d = T_WAIT_BUSY;
      end
      // The uart may take a cycle or two to show the load; give up after BUSY_TIMEOUT.
      T_WAIT_BUSY: begin
        if (!tx_empty) begin
          tx_state_d = T_WAIT_EMPTY;
        end else if (cnt_q == CNT_W'(BUSY_TIMEOUT - 1)) begin
          tmo_d      = 1'b1;
          tx_state_d = T_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      T_WAIT_EMPTY: begin
        if (tx_empty) tx_state_d = T_IDLE;
      end
      default: tx_state_d = T_IDLE;
    endcase
  end

  always_comb begin
    rx_state_d = rx_state_q;
    uld_d      = 1'b0;
    rx_byte_d  = rx_byte_q;
    rx_valid_d = rx_valid_q;
    case (rx_state_q)
      R_IDLE: begin
        if (enable && !rx_empty && !rx_valid_q) begin
          uld_d      = 1'b1;
          rx_state_d = R_CAPT;
        end
      end
      // Skip the cycle the unload strobe is live so the uart has updated rx_data.
      R_CAPT: begin
        if (!uld_q) begin
          rx_byte_d  = rx_data;
          rx_valid_d = 1'b1;
          rx_state_d = R_HOLD;
        end
      end
      R_HOLD: begin
        if (rx_valid_q && rx_ready) begin
          rx_valid_d = 1'b0;
          rx_state_d = R_IDLE;
        end
      end
      default: rx_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_state_q  <= T_IDLE;
      ptr_q       <= '0;
      lock_q      <= 1'b0;
      gid_q       <= '0;
      tx_data_q   <= '0;
      req_ready_q <= '0;
      ld_q        <= 1'b0;
      cnt_q       <= '0;
      tmo_q       <= 1'b0;
      en_q        <= 1'b0;
      rx_state_q  <= R_IDLE;
      uld_q       <= 1'b0;
      rx_byte_q   <= '0;
      rx_valid_q  <= 1'b0;
    end else begin
      tx_state_q  <= tx_state_d;
      ptr_q       <= ptr_d;
      lock_q      <= lock_d;
      gid_q       <= gid_d;
      tx_data_q   <= tx_data_d;
      req_ready_q <= req_ready_d;
      ld_q        <= ld_d;
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
      en_q        <= enable;
      rx_state_q  <= rx_state_d;
      uld_q       <= uld_d;
      rx_byte_q   <= rx_byte_d;
      rx_valid_q  <= rx_valid_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign grant_id    = gid_q;
  assign ld_tx_data  = ld_q;
  assign tx_data     = tx_data_q;
  assign tx_enable   = en_q;
  assign rx_enable   = en_q;
  assign uld_rx_data = uld_q;
  assign rx_byte     = rx_byte_q;
  assign rx_valid    = rx_valid_q;
  assign busy        = (tx_state_q != T_IDLE);
  assign timeout_err = tmo_q;

endmodule

// File: tb/tb_uart_ctrl.sv
// tb/tb_uart_ctrl.sv - directed self-checking bench for uart_ctrl
module tb_uart_ctrl;

  localparam int BT = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic [1:0]  grant_id;
  logic        ld_tx_data;
  logic [7:0]  tx_data;
  logic        tx_enable;
  logic        tx_empty = 1'b1;
  logic        rx_enable;
  logic        uld_rx_data;
  logic [7:0]  rx_data;
  logic        rx_empty;
  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic        rx_ready;
  logic        busy;
  logic        timeout_err;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [3:0] rr;
    logic [1:0] id;
    logic [7:0] data;
  } gnt_t;
  gnt_t gq[$];
  int   dbl_cnt = 0;
  int   uld_cnt = 0;
  logic [3:0] prev_rr = '0;
  bit   tx_stuck = 1'b0;
  int   busy_cnt = 0;

  uart_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .grant_id    (grant_id),
    .ld_tx_data  (ld_tx_data),
    .tx_data     (tx_data),
    .tx_enable   (tx_enable),
    .tx_empty    (tx_empty),
    .rx_enable   (rx_enable),
    .uld_rx_data (uld_rx_data),
    .rx_data     (rx_data),
    .rx_empty    (rx_empty),
    .rx_byte     (rx_byte),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  // uart TX model: after a load, holds tx_empty low for 10 cycles
  always @(negedge clk) begin
    if (!reset) begin
      tx_empty = 1'b1;
      busy_cnt = 0;
    end else if (ld_tx_data && !tx_stuck) begin
      tx_empty = 1'b0;
      busy_cnt = 10;
    end else if (busy_cnt > 0) begin
      busy_cnt = busy_cnt - 1;
      if (busy_cnt == 0) tx_empty = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (req_ready != 4'b0) begin
      gq.push_back('{rr: req_ready, id: grant_id, data: tx_data});
      if (prev_rr != 4'b0) dbl_cnt++;
    end
    prev_rr = req_ready;
    if (uld_rx_data) uld_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  function automatic bit cond(input int sel);
    case (sel)
      0: return !busy;
      1: return ld_tx_data;
      2: return uld_rx_data;
      3: return rx_valid;
      4: return !tx_empty;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_for(input string tag, input int sel, input int budget);
    int n = 0;
    while (!cond(sel) && n < budget) begin
      step();
      n++;
    end
    check(tag, 32'(cond(sel)), 32'd1);
  endtask

  task automatic wait_grants(input string tag, input int cnt, input int budget);
    int n = 0;
    while (gq.size() < cnt && n < budget) begin
      step();
      n++;
    end
    check(tag, 32'(gq.size()), 32'(cnt));
  endtask

  task automatic check_gnt(input string tag, input int k, input int id, input logic [7:0] data);
    check({tag, "_id"}, 32'(gq[k].id), 32'(id));
    check({tag, "_rr"}, 32'(gq[k].rr), 32'(4'b0001 << id));
    check({tag, "_data"}, 32'(gq[k].data), 32'(data));
  endtask

  int stable_bad;
  int uld_base;

  initial begin
    reset     = 1'b0;
    enable    = 1'b1;
    req_valid = 4'b1111;
    req_data  = 32'h13121110;
    req_last  = 4'b1111;
    rx_data   = 8'h00;
    rx_empty  = 1'b1;
    rx_ready  = 1'b0;

    // 1: reset holds outputs low, then first grant and load timing
    step(); step(); step();
    check("rst_outs", 32'({req_ready, grant_id, ld_tx_data, tx_data, tx_enable, rx_enable,
                          uld_rx_data, rx_byte, rx_valid, busy, timeout_err}), 32'd0);
    reset = 1'b1;
    step();
    check("t1_rr", 32'(req_ready), 32'h1);
    check("t1_gid", 32'(grant_id), 32'h0);
    check("t1_data", 32'(tx_data), 32'h10);
    check("t1_ld_early", 32'(ld_tx_data), 32'h0);
    check("t1_txen", 32'(tx_enable), 32'h1);
    step();
    check("t1_ld", 32'(ld_tx_data), 32'h1);
    check("t1_rr_pulse", 32'(req_ready), 32'h0);
    step();
    check("t1_ld_pulse", 32'(ld_tx_data), 32'h0);

    // 2: round robin with all requesters valid, single-byte frames
    wait_grants("t2_wait", 5, 300);
    req_valid = 4'b0000;
    check_gnt("t2_g0", 0, 0, 8'h10);
    check_gnt("t2_g1", 1, 1, 8'h11);
    check_gnt("t2_g2", 2, 2, 8'h12);
    check_gnt("t2_g3", 3, 3, 8'h13);
    check_gnt("t2_g4", 4, 0, 8'h10);
    check("t2_dbl", 32'(dbl_cnt), 32'd0);

    // 3: locked frame from requester 2 with requester 1 competing
    wait_for("t3_idle", 0, 60);
    gq.delete();
    req_data[23:16] = 8'hA1;
    req_last[2]     = 1'b0;
    req_valid       = 4'b0100;
    wait_grants("t3_w1", 1, 40);
    req_data[15:8] = 8'h21;
    req_last[1]    = 1'b1;
    req_valid      = 4'b0010;
    repeat (40) step();
    check("t3_lock_hold", 32'(gq.size()), 32'd1);
    req_data[23:16] = 8'hA2;
    req_valid       = 4'b0110;
    wait_grants("t3_w2", 2, 40);
    req_data[23:16] = 8'hA3;
    req_last[2]     = 1'b1;
    wait_grants("t3_w3", 3, 40);
    req_valid = 4'b0010;
    wait_grants("t3_w4", 4, 40);
    req_valid = 4'b0000;
    check_gnt("t3_g0", 0, 2, 8'hA1);
    check_gnt("t3_g1", 1, 2, 8'hA2);
    check_gnt("t3_g2", 2, 2, 8'hA3);
    check_gnt("t3_g3", 3, 1, 8'h21);

    // 4: uart never leaves empty -> timeout after BT cycles, then recovery
    wait_for("t4_idle", 0, 60);
    gq.delete();
    tx_stuck        = 1'b1;
    req_data[31:24] = 8'h33;
    req_valid       = 4'b1000;
    wait_for("t4_ld", 1, 20);
    req_valid = 4'b0000;
    check("t4_gid", 32'(grant_id), 32'h3);
    check("t4_data", 32'(tx_data), 32'h33);
    repeat (BT - 1) step();
    check("t4_tmo_early", 32'(timeout_err), 32'h0);
    step();
    check("t4_tmo", 32'(timeout_err), 32'h1);
    check("t4_idle_after", 32'(busy), 32'h0);
    tx_stuck       = 1'b0;
    req_data[7:0]  = 8'h44;
    req_valid      = 4'b0001;
    wait_grants("t4_wnext", 2, 40);
    req_valid = 4'b0000;
    check_gnt("t4_next", 1, 0, 8'h44);
    check("t4_sticky", 32'(timeout_err), 32'h1);

    // 5: RX unload with backpressure
    rx_data  = 8'h5C;
    rx_empty = 1'b0;
    wait_for("t5_uld", 2, 10);
    rx_empty = 1'b1;
    uld_base = uld_cnt;
    wait_for("t5_valid", 3, 10);
    check("t5_byte", 32'(rx_byte), 32'h5C);
    rx_data    = 8'h3E;
    rx_empty   = 1'b0;
    stable_bad = 0;
    repeat (20) begin
      step();
      if (rx_byte !== 8'h5C || rx_valid !== 1'b1) stable_bad++;
    end
    check("t5_no_uld", 32'(uld_cnt - uld_base), 32'd0);
    check("t5_stable", 32'(stable_bad), 32'd0);
    rx_ready = 1'b1;
    step();
    rx_ready = 1'b0;
    check("t5_hs_clr", 32'(rx_valid), 32'h0);
    wait_for("t5_uld2", 2, 10);
    rx_empty = 1'b1;
    wait_for("t5_valid2", 3, 10);
    check("t5_uld_cnt", 32'(uld_cnt - uld_base), 32'd1);
    check("t5_byte2", 32'(rx_byte), 32'h3E);
    rx_ready = 1'b1;
    step();
    rx_ready = 1'b0;

    // 6: reset during WAIT_EMPTY with lock held restarts arbitration at 0
    wait_for("t6_idle", 0, 60);
    gq.delete();
    req_data[15:8] = 8'h61;
    req_last[1]    = 1'b0;
    req_valid      = 4'b0010;
    wait_grants("t6_w1", 1, 40);
    wait_for("t6_txbusy", 4, 20);
    step(); step();
    reset = 1'b0;
    #1;
    check("t6_busy", 32'(busy), 32'h0);
    check("t6_outs", 32'({req_ready, grant_id, ld_tx_data, tx_data, tx_enable, timeout_err}), 32'd0);
    req_data[7:0] = 8'h70;
    req_last[0]   = 1'b1;
    req_valid     = 4'b0011;
    step(); step(); step();
    gq.delete();
    reset = 1'b1;
    wait_grants("t6_w2", 1, 20);
    check_gnt("t6_first", 0, 0, 8'h70);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_ctrl.md
Name: uart_ctrl

Overview:
Single-clock controller that sequences the `uart` block.
- TX side: round-robin arbitration of `NUM_REQ` byte-stream requesters onto the UART transmitter. A frame lock keeps the grant on one requester until it asserts `req_last`.
- RX side: unloads received bytes from the UART and presents them on a valid/ready stream.
- Placement: between on-chip clients and the `uart` instance; drives its `ld_tx_data`, `tx_data`, `tx_enable`, `uld_rx_data` and `rx_enable`.

Parameters:
- `NUM_REQ`, default 4, number of TX requesters (2..8).
- `DATA_W`, default 8, byte width; must match the uart data width.
- `BUSY_TIMEOUT`, default 16, cycles to wait for `tx_empty` to fall after a load before flagging an error.

Ports:
- `clk`  in  1  system clock; the uart is clocked from the same clock.
- `reset`  in  1  asynchronous, active-low reset.
- `enable`  in  1  global enable; drives `tx_enable` and `rx_enable`.
- `req_valid`  in  `NUM_REQ`  per-requester byte valid.
- `req_data`  in  `NUM_REQ*DATA_W`  per-requester byte; requester i occupies bits [i*DATA_W +: DATA_W].
- `req_last`  in  `NUM_REQ`  marks the final byte of a frame.
- `req_ready`  out  `NUM_REQ`  one-hot acceptance strobe.
- `grant_id`  out  `$clog2(NUM_REQ)`  current or last granted requester.
- `ld_tx_data`  out  1  load strobe to the uart.
- `tx_data`  out  `DATA_W`  byte to the uart.
- `tx_enable`  out  1  uart TX enable.
- `tx_empty`  in  1  uart TX holding register empty.
- `rx_enable`  out  1  uart RX enable.
- `uld_rx_data`  out  1  unload strobe to the uart.
- `rx_data`  in  `DATA_W`  uart received byte.
- `rx_empty`  in  1  uart RX register empty.
- `rx_byte`  out  `DATA_W`  received byte to the consumer.
- `rx_valid`  out  1  `rx_byte` is valid.
- `rx_ready`  in  1  consumer accepts.
- `busy`  out  1  TX FSM not in `T_IDLE`.
- `timeout_err`  out  1  sticky; cleared only by reset.

Behaviour:
- Reset values: all outputs 0. Round-robin pointer = 0, lock = 0, both FSMs idle. Reset asserted mid-operation aborts immediately; a half-issued `ld_tx_data` is dropped.
- `tx_enable` = `rx_enable` = `enable`, registered (1-cycle delay).
- TX FSM states:
  - `T_IDLE`: requires `enable` and `tx_empty`.
    - If lock = 1: the locked requester is the only candidate.
    - Otherwise: the first valid requester at or after the pointer (wrapping modulo `NUM_REQ`).
    - On a selection: register the byte into `tx_data`, pulse `req_ready[g]` for exactly 1 cycle, set `grant_id`, and go to `T_LOAD`.
  - `T_LOAD`: `ld_tx_data` = 1 for exactly 1 cycle, then go to `T_WAIT_BUSY`.
  - `T_WAIT_BUSY`: wait for `tx_empty` = 0.
    - If `tx_empty` is still 1 after `BUSY_TIMEOUT` cycles, set `timeout_err` and go to `T_IDLE`. Lock and pointer are updated as on normal completion.
  - `T_WAIT_EMPTY`: wait for `tx_empty` = 1, then go to `T_IDLE`.
- Lock and pointer update, applied on the `T_IDLE`→`T_LOAD` transition:
  - lock = !`req_last[g]`.
  - If `req_last[g]`: pointer = (g+1) mod `NUM_REQ`.
  - Otherwise the pointer is unchanged.
- Locked requester drops `req_valid`: the FSM waits in `T_IDLE`; there is no preemption.
- Pipelining: minimum request-to-`ld_tx_data` latency is 2 cycles. Back-to-back bytes are limited by uart serialisation.
- `enable` = 0: no new grants. An in-flight byte completes its FSM path. Lock is retained.
- RX FSM states:
  - `R_IDLE`: if `enable` and `rx_empty` = 0 and `rx_valid` = 0, pulse `uld_rx_data` for 1 cycle and go to `R_CAPT`.
  - `R_CAPT`: 1 cycle later, capture `rx_data` into `rx_byte`, set `rx_valid`, go to `R_HOLD`.
  - `R_HOLD`: hold `rx_byte` stable. Clear `rx_valid` on `rx_valid` & `rx_ready`, then go to `R_IDLE`.
  - Backpressure: no unload while `rx_valid` = 1. Uart overrun is the uart's concern.
- TX and RX FSMs are independent; simultaneous events on both sides are allowed.

Decomposition:
- Package `uart_ctrl_pkg`:
  - TX state enum: `T_IDLE`, `T_LOAD`, `T_WAIT_BUSY`, `T_WAIT_EMPTY`.
  - RX state enum: `R_IDLE`, `R_CAPT`, `R_HOLD`.
  - Timeout counter width: `$clog2(BUSY_TIMEOUT+1)`.
- Sub-module `rr_arbiter`: combinational round-robin select with lock override. Inputs: `req`, pointer, lock, locked id. Outputs: `gnt_valid`, `gnt_id`.

Test Plan:
1. Reset with `req_valid` = 4'b1111 held → all outputs 0 until `reset` = 1. First grant goes to requester 0, `tx_data` = `req_data[0]`, `ld_tx_data` 2 cycles after the first `clk` edge with `enable` = 1.
2. `req_valid` = 4'b1111, all `req_last` = 1, uart model holds `tx_empty` = 0 for 10 cycles per byte → grant order 0,1,2,3,0. Each `req_ready` is a 1-cycle pulse.
3. Requester 2 sends a 3-byte frame 0xA1, 0xA2, 0xA3 (`req_last` on 0xA3) while requester 1 is valid → `tx_data` sequence A1,A2,A3, then requester 1 is granted and the pointer equals 3.
4. Uart model never drops `tx_empty` after a load → `timeout_err` = 1 exactly `BUSY_TIMEOUT` cycles after `ld_tx_data`. The next grant still proceeds.
5. `rx_empty` falls with `rx_data` = 0x5C, `rx_ready` = 0 for 20 cycles → one `uld_rx_data` pulse, `rx_byte` = 0x5C stable. A second byte is not unloaded until the handshake completes.
6. Assert `reset` = 0 while in `T_WAIT_EMPTY` with lock = 1 → lock cleared, `busy` = 0 immediately. After reset release, arbitration restarts at requester 0.
